// File: rtl/apb3_pkg.sv
// Shared APB3 completer types, constants and the address-decode error rule.
package apb3_pkg;

  typedef enum logic [0:0] {IDLE, ACCESS} apb3_state_e;

  localparam int unsigned APB3_WORD_BYTES = 4;
  localparam logic [31:0] APB3_DEFAULT_ID = 32'hA9B3_0001;

  // Misaligned, out-of-range, or a write to the read-only ID word.
  function automatic logic apb3_decode_err(input logic [31:0] addr, input logic write,
                                           input int unsigned num_regs);
    logic [31:0] idx;
    idx = addr / APB3_WORD_BYTES;
    return (addr[1:0] != 2'b00) || (idx >= num_regs) || (write && (idx == 32'd0));
  endfunction

endpackage

// File: rtl/apb3_reg_bank.sv
// Word register bank: register 0 is a constant ID, the rest are writable.
module apb3_reg_bank
  import apb3_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = 10,
  parameter logic [31:0] ID_VALUE   = APB3_DEFAULT_ID
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [IDX_W-1:0]               idx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);

  assign regs[DATA_WIDTH-1:0] = DATA_WIDTH'(ID_VALUE);

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    logic [DATA_WIDTH-1:0] r;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r <= '0;
      else if (we && (idx == IDX_W'(g)))
        r <= wdata;
    end

    assign regs[g*DATA_WIDTH +: DATA_WIDTH] = r;
  end

endmodule

// File: rtl/apb3_completer.sv
// APB3 completer: wait-state FSM, registered response, decode errors, register bank.
module apb3_completer
  import apb3_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = APB3_DEFAULT_ID
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("apb3_completer: WAIT_CYCLES must be in 0..15");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("apb3_completer: only DATA_WIDTH=32 is supported");
  end

  apb3_state_e           state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  pready_n, pslverr_n;
  logic [DATA_WIDTH-1:0] prdata_n;
  logic                  latch, we;
  logic [IDX_W-1:0]      idx_q, rd_idx, paddr_idx;
  logic                  wr_q, err_q, setup_err;
  logic [DATA_WIDTH-1:0] rd_word;

  assign paddr_idx = PADDR[ADDR_WIDTH-1:2];
  assign setup_err = apb3_decode_err(32'(PADDR), PWRITE, NUM_REGS);
  // Zero-wait reads are answered at the setup edge, before idx_q is loaded.
  assign rd_idx    = (state == IDLE) ? paddr_idx : idx_q;

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (rd_idx == IDX_W'(i))
        rd_word = regs_o[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pready_n  = PREADY;
    prdata_n  = PRDATA;
    pslverr_n = PSLVERR;
    latch     = 1'b0;
    we        = 1'b0;
    case (state)
      IDLE: begin
        pready_n  = 1'b0;
        prdata_n  = '0;
        pslverr_n = 1'b0;
        if (PSEL && !PENABLE) begin
          state_n = ACCESS;
          cnt_n   = 4'(WAIT_CYCLES);
          latch   = 1'b1;
          if (WAIT_CYCLES == 0) begin
            pready_n  = 1'b1;
            pslverr_n = setup_err;
            prdata_n  = (!PWRITE && !setup_err) ? rd_word : '0;
          end
        end
      end
      ACCESS: begin
        if (!(PSEL && PENABLE)) begin
          // Requester abandoned the transfer: drop it without writing.
          state_n   = IDLE;
          cnt_n     = '0;
          pready_n  = 1'b0;
          prdata_n  = '0;
          pslverr_n = 1'b0;
        end else if (!PREADY) begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) begin
            pready_n  = 1'b1;
            pslverr_n = err_q;
            prdata_n  = (!wr_q && !err_q) ? rd_word : '0;
          end
        end else begin
          we        = wr_q && !err_q;
          state_n   = IDLE;
          cnt_n     = '0;
          pready_n  = 1'b0;
          prdata_n  = '0;
          pslverr_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      PREADY  <= pready_n;
      PRDATA  <= prdata_n;
      PSLVERR <= pslverr_n;
    end
  end

  always_ff @(posedge PCLK) begin
    if (latch) begin
      idx_q <= paddr_idx;
      wr_q  <= PWRITE;
      err_q <= setup_err;
    end
  end

  apb3_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W),
    .ID_VALUE  (ID_VALUE)
  ) u_bank (
    .clk  (PCLK),
    .rst_n(PRESETn),
    .we   (we),
    .idx  (idx_q),
    .wdata(PWDATA),
    .regs (regs_o)
  );

endmodule

// File: tb/tb_apb3_completer.sv
// Directed bench for apb3_completer with 2 and 0 wait states, scoreboarded responses.
module tb_apb3_completer;

  localparam logic [31:0] ID = 32'hA9B3_0001;

  logic         clk = 1'b0;
  logic         presetn;
  logic         psel, penable, pwrite, use_w0;
  logic [11:0]  paddr;
  logic [31:0]  pwdata;
  logic         pready_w2, pslverr_w2, pready_w0, pslverr_w0;
  logic [31:0]  prdata_w2, prdata_w0;
  logic [511:0] regs_w2, regs_w0;
  logic         pready, pslverr;
  logic [31:0]  prdata;
  logic [511:0] regs;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb3_completer #(.WAIT_CYCLES(2)) u_w2 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel && !use_w0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready_w2),
    .PRDATA(prdata_w2), .PSLVERR(pslverr_w2), .regs_o(regs_w2)
  );

  apb3_completer #(.WAIT_CYCLES(0)) u_w0 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel && use_w0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready_w0),
    .PRDATA(prdata_w0), .PSLVERR(pslverr_w0), .regs_o(regs_w0)
  );

  assign pready  = use_w0 ? pready_w0  : pready_w2;
  assign pslverr = use_w0 ? pslverr_w0 : pslverr_w2;
  assign prdata  = use_w0 ? prdata_w0  : prdata_w2;
  assign regs    = use_w0 ? regs_w0    : regs_w2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_word(input int i);
    return regs[i*32 +: 32];
  endfunction

  task automatic idle_cycle();
    psel = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
  endtask

  // Setup phase, then access cycles until PREADY; returns just after the completion edge.
  task automatic xfer(input string tag, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_waits);
    exp_t e;
    int   waits;
    bit   done;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.waits = exp_waits;
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (pready) begin
        e = sb.pop_front();
        check({tag, ".waits"},   32'(waits),   32'(e.waits));
        check({tag, ".pslverr"}, 32'(pslverr), 32'(e.err));
        check({tag, ".prdata"},  prdata,       e.rdata);
        done = 1'b1;
      end else begin
        check({tag, ".quiet"}, {prdata[31:1], prdata[0] | pslverr}, 32'd0);
        waits++;
      end
      @(posedge clk); #1;
    end
    check({tag, ".pready_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    presetn = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; use_w0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.pready",  32'(pready),  32'd0);
    check("rst.pslverr", 32'(pslverr), 32'd0);
    check("rst.prdata",  prdata,       32'd0);
    check("rst.reg0",    reg_word(0),  ID);
    check("rst.reg5",    reg_word(5),  32'd0);
    presetn = 1'b1;
    idle_cycle();

    xfer("id_read", 1'b0, 12'h000, 32'h0, ID, 1'b0, 2);
    idle_cycle();
    xfer("wr14", 1'b1, 12'h014, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("wr14.reg5", reg_word(5), 32'hDEADBEEF);
    check("wr14.cleared", 32'(pready), 32'd0);
    idle_cycle();
    xfer("rd14", 1'b0, 12'h014, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    idle_cycle();
    xfer("wr_id", 1'b1, 12'h000, 32'h12345678, 32'h0, 1'b1, 2);
    check("wr_id.reg0", reg_word(0), ID);
    idle_cycle();
    xfer("rd42", 1'b0, 12'h042, 32'h0, 32'h0, 1'b1, 2);
    idle_cycle();
    xfer("rd40", 1'b0, 12'h040, 32'h0, 32'h0, 1'b1, 2);
    idle_cycle();

    use_w0 = 1'b1;
    idle_cycle();
    t0 = cyc;
    xfer("b2b_wr", 1'b1, 12'h004, 32'h5A5A1234, 32'h0, 1'b0, 0);
    xfer("b2b_rd", 1'b0, 12'h004, 32'h0, 32'h5A5A1234, 1'b0, 0);
    check("b2b.cycles", 32'(cyc - t0), 32'd4);
    check("b2b.reg1", reg_word(1), 32'h5A5A1234);
    idle_cycle();

    use_w0 = 1'b0;
    idle_cycle();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("abort.pready",  32'(pready),  32'd0);
    check("abort.pslverr", 32'(pslverr), 32'd0);
    check("abort.reg2",    reg_word(2),  32'd0);
    xfer("abort.rd8", 1'b0, 12'h008, 32'h0, 32'h0, 1'b0, 2);
    idle_cycle();

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h00001234;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst.pready_pre", 32'(pready), 32'd1);
    #2 presetn = 1'b0;
    #1;
    check("midrst.pready",  32'(pready),  32'd0);
    check("midrst.pslverr", 32'(pslverr), 32'd0);
    check("midrst.prdata",  prdata,       32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    presetn = 1'b1;
    @(posedge clk); #1;
    check("midrst.reg3", reg_word(3), 32'd0);
    check("midrst.reg5", reg_word(5), 32'd0);
    check("midrst.reg0", reg_word(0), ID);
    xfer("post_rst_rd", 1'b0, 12'h00C, 32'h0, 32'h0, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
